// File: rtl/key_matrix_map.sv
// key_matrix_map: PS/2 scancode to emulated keyboard matrix mapper.
// The scancode lookup comes from a programmable map RAM. A FIFO-fed sequencer
// injects timed key presses. An active-low override bus is ANDed into the
// matrix. The selected row is presented to the host scan logic as a
// registered value.
module key_matrix_map #(
   parameter int          ROWS       = 8,
   parameter int          COLS       = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] HOLD_CYC   = 16'd40000,
   parameter logic [15:0] GAP_CYC    = 16'd40000,
   localparam int         RW         = $clog2(ROWS),
   localparam int         CW         = $clog2(COLS),
   localparam int         MW         = 1 + RW + CW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 strb,
   input  logic                 make,
   input  logic                 extd,
   input  logic [7:0]           code,
   input  logic                 map_we,
   input  logic [8:0]           map_addr,
   input  logic [MW-1:0]        map_data,
   input  logic                 clr_all,
   input  logic                 inj_valid,
   output logic                 inj_ready,
   input  logic [RW-1:0]        inj_row,
   input  logic [CW-1:0]        inj_col,
   output logic                 inj_busy,
   input  logic [ROWS*COLS-1:0] ext_n,
   input  logic [RW-1:0]        row,
   input  logic [COLS-1:0]      col,
   output logic [COLS-1:0]      row_keys,
   output logic                 keyHit
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

   // ---------------------------------------------------------------- map RAM
   logic [MW-1:0] map_ram [512];
   logic [MW-1:0] ev_entry;
   logic          ev_make;
   logic          ev_valid;
   logic [RW-1:0] ev_row;
   logic [CW-1:0] ev_col;

   assign ev_row = ev_entry[RW+CW-1:CW];
   assign ev_col = ev_entry[CW-1:0];

   // Map RAM write plus registered lookup; the lookup sees pre-write contents.
   // NOTE: RAM and its read register carry no reset; ev_valid alone qualifies the entry.
   always_ff @(posedge clock) begin
      if (map_we) map_ram[map_addr] <= map_data;
      ev_entry <= map_ram[{extd, code}];
      ev_make  <= make;
   end

   // Event strobe stage; reset discards an in-flight event.
   always_ff @(posedge clock) begin
      if (reset) ev_valid <= 1'b0;
      else       ev_valid <= strb;
   end

   // ------------------------------------------------------------- ps2 matrix
   logic [ROWS-1:0][COLS-1:0] ps2;

   // Apply a mapped event; clr_all wins over a same-edge event.
   always_ff @(posedge clock) begin
      if (reset || clr_all) begin
         ps2 <= '1;
      end else if (ev_valid && ev_entry[MW-1] &&
                   int'(ev_row) < ROWS && int'(ev_col) < COLS) begin
         ps2[ev_row][ev_col] <= ~ev_make;
      end
   end

   // --------------------------------------------------------- injection FIFO
   logic [RW+CW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full, push, pop;
   state_t           state, state_next;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = (state == S_IDLE) && !fifo_empty;
   // A full FIFO still takes a push on the edge that pops it.
   assign inj_ready  = !fifo_full || pop;
   assign push       = inj_valid && inj_ready;
   assign inj_busy   = !fifo_empty || (state != S_IDLE);

   // FIFO storage write.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {inj_row, inj_col};
   end

   // FIFO pointers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // -------------------------------------------------------------- sequencer
   logic [15:0]   cnt, cnt_next;
   logic [RW-1:0] key_row;
   logic [CW-1:0] key_col;

   // Latch the popped key; only meaningful while in PRESS.
   always_ff @(posedge clock) begin
      if (pop) {key_row, key_col} <= fifo_mem[rd_ptr[AW-1:0]];
   end

   // Sequencer state and timer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Sequencer next state: hold the key HOLD_CYC cycles, then force a GAP_CYC release.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_next = S_PRESS;
               cnt_next   = HOLD_CYC - 16'd1;
            end
         end
         S_PRESS: begin
            if (cnt == 16'd0) begin
               state_next = S_GAP;
               cnt_next   = GAP_CYC - 16'd1;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end
         S_GAP: begin
            if (cnt == 16'd0) state_next = S_IDLE;
            else              cnt_next   = cnt - 16'd1;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------- effective state
   logic [ROWS-1:0][COLS-1:0] inj_n, ext_m, eff;
   logic [COLS-1:0]           sel_keys;

   assign ext_m = ext_n;
   assign eff   = ps2 & inj_n & ext_m;

   // Injected key mask: low only for the latched key while pressed.
   always_comb begin
      inj_n = '1;
      if (state == S_PRESS && int'(key_row) < ROWS && int'(key_col) < COLS)
         inj_n[key_row][key_col] = 1'b0;
   end

   // Row select; an out-of-range row reads as all released.
   always_comb begin
      sel_keys = '1;
      for (int r = 0; r < ROWS; r++)
         if (int'(row) == r) sel_keys = eff[r];
   end

   // Registered scan outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         row_keys <= '1;
         keyHit   <= 1'b0;
      end else begin
         row_keys <= sel_keys;
         keyHit   <= ((sel_keys | col) != '1);
      end
   end

endmodule

// File: tb/tb_key_matrix_map.sv
// Directed testbench for key_matrix_map (HOLD_CYC=4, GAP_CYC=3).
module tb_key_matrix_map;

   logic        clock = 1'b0;
   logic        reset, strb, make, extd, map_we, clr_all, inj_valid;
   logic [7:0]  code;
   logic [8:0]  map_addr;
   logic [6:0]  map_data;
   logic [2:0]  inj_row, inj_col, row;
   logic [63:0] ext_n;
   logic [7:0]  col;
   logic        inj_ready, inj_busy, keyHit;
   logic [7:0]  row_keys;

   int checks = 0;
   int errors = 0;

   key_matrix_map #(
      .ROWS(8), .COLS(8), .FIFO_DEPTH(8), .HOLD_CYC(16'd4), .GAP_CYC(16'd3)
   ) dut (
      .clock(clock), .reset(reset), .strb(strb), .make(make), .extd(extd),
      .code(code), .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
      .clr_all(clr_all), .inj_valid(inj_valid), .inj_ready(inj_ready),
      .inj_row(inj_row), .inj_col(inj_col), .inj_busy(inj_busy),
      .ext_n(ext_n), .row(row), .col(col), .row_keys(row_keys), .keyHit(keyHit)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_map(input logic [8:0] a, input logic [6:0] d);
      map_addr = a; map_data = d; map_we = 1'b1;
      tick();
      map_we = 1'b0;
   endtask

   // Strobe one event and wait until it has reached the ps2 matrix.
   task automatic send(input logic e, input logic [7:0] c, input logic m);
      extd = e; code = c; make = m; strb = 1'b1;
      tick();
      strb = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL rst_row_keys got %h exp ff", row_keys); end
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL rst_keyhit got %b exp 0", keyHit); end
      checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL rst_inj_ready got %b exp 1", inj_ready); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL rst_inj_busy got %b exp 0", inj_busy); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_make_break();
      wr_map({1'b0, 8'h1C}, {1'b1, 3'd6, 3'd5});
      row = 3'd6; col = 8'hDF;
      tick();
      extd = 1'b0; code = 8'h1C; make = 1'b1; strb = 1'b1;
      tick();
      strb = 1'b0;
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL mb_lat1 got %b exp 0", keyHit); end
      tick();
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL mb_lat2 got %b exp 0", keyHit); end
      tick();
      checks++; if (keyHit !== 1'b1) begin errors++; $display("FAIL mb_make_hit got %b exp 1", keyHit); end
      checks++; if (row_keys !== 8'hDF) begin errors++; $display("FAIL mb_make_row got %h exp df", row_keys); end
      col = 8'hFF;
      tick();
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL mb_undriven got %b exp 0", keyHit); end
      col = 8'hDF;
      tick();
      make = 1'b0; strb = 1'b1;
      tick();
      strb = 1'b0;
      tick();
      checks++; if (keyHit !== 1'b1) begin errors++; $display("FAIL mb_break_lat got %b exp 1", keyHit); end
      tick();
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL mb_break_hit got %b exp 0", keyHit); end
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL mb_break_row got %h exp ff", row_keys); end
   endtask

   task automatic test_extended();
      wr_map({1'b1, 8'h11}, {1'b1, 3'd5, 3'd4});
      wr_map({1'b0, 8'h11}, {1'b1, 3'd4, 3'd6});
      col = 8'hFF;
      send(1'b1, 8'h11, 1'b1);
      row = 3'd5; tick();
      checks++; if (row_keys !== 8'hEF) begin errors++; $display("FAIL ext_row5 got %h exp ef", row_keys); end
      row = 3'd4; tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL ext_row4 got %h exp ff", row_keys); end
      send(1'b1, 8'h11, 1'b0);
      row = 3'd5; tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL ext_release got %h exp ff", row_keys); end
   endtask

   task automatic test_invalid_and_rbw();
      wr_map({1'b0, 8'h7E}, {1'b0, 3'd2, 3'd2});
      send(1'b0, 8'h7E, 1'b1);
      for (int r = 0; r < 8; r++) begin
         row = r[2:0]; tick();
         checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL inv_row%0d got %h exp ff", r, row_keys); end
      end
      wr_map({1'b0, 8'h2A}, {1'b1, 3'd1, 3'd1});
      map_addr = {1'b0, 8'h2A}; map_data = {1'b1, 3'd2, 3'd2}; map_we = 1'b1;
      extd = 1'b0; code = 8'h2A; make = 1'b1; strb = 1'b1;
      tick();
      map_we = 1'b0; strb = 1'b0;
      tick();
      row = 3'd1; tick();
      checks++; if (row_keys !== 8'hFD) begin errors++; $display("FAIL rbw_old_row1 got %h exp fd", row_keys); end
      row = 3'd2; tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL rbw_new_row2 got %h exp ff", row_keys); end
      send(1'b0, 8'h2A, 1'b1);
      tick();
      checks++; if (row_keys !== 8'hFB) begin errors++; $display("FAIL rbw_written got %h exp fb", row_keys); end
      clr_all = 1'b1; tick(); clr_all = 1'b0;
      row = 3'd1; tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL rbw_clr got %h exp ff", row_keys); end
   endtask

   task automatic test_injection();
      logic [7:0] exp_rk;
      logic       exp_busy;
      col = 8'hFF;
      for (int n = 1; n <= 26; n++) begin
         inj_valid = (n <= 3);
         inj_row   = (n == 3) ? 3'd7 : 3'd2;
         inj_col   = (n == 3) ? 3'd0 : 3'd3;
         row       = (n <= 16) ? 3'd2 : 3'd7;
         tick();
         if (n <= 16) exp_rk = ((n >= 3 && n <= 6) || (n >= 11 && n <= 14)) ? 8'hF7 : 8'hFF;
         else         exp_rk = (n >= 19 && n <= 22) ? 8'hFE : 8'hFF;
         exp_busy = (n <= 24);
         checks++; if (row_keys !== exp_rk) begin errors++; $display("FAIL inj_rk cyc %0d got %h exp %h", n, row_keys, exp_rk); end
         checks++; if (inj_busy !== exp_busy) begin errors++; $display("FAIL inj_busy cyc %0d got %b exp %b", n, inj_busy, exp_busy); end
      end
      inj_valid = 1'b0;
   endtask

   task automatic test_fifo_full();
      int fall = 0;
      row = 3'd0; col = 8'hFF;
      for (int n = 1; n <= 11; n++) begin
         inj_valid = 1'b1; inj_row = n[2:0]; inj_col = 3'd1;
         tick();
         if (n == 9) begin
            checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", inj_ready); end
         end
         if (n >= 10) begin
            checks++; if (inj_ready !== 1'b0) begin errors++; $display("FAIL full_ready cyc %0d got %b exp 0", n, inj_ready); end
         end
      end
      inj_valid = 1'b0;
      for (int n = 12; n <= 200; n++) begin
         tick();
         if (!inj_busy) begin fall = n; break; end
      end
      checks++; if (fall != 81) begin errors++; $display("FAIL full_drain busy fell at cyc %0d exp 81", fall); end
   endtask

   task automatic test_reset_mid_press();
      row = 3'd0; col = 8'h00;
      inj_valid = 1'b1; inj_row = 3'd0; inj_col = 3'd7;
      tick();
      inj_row = 3'd1; inj_col = 3'd1;
      tick();
      inj_valid = 1'b0;
      tick();
      checks++; if (row_keys !== 8'h7F) begin errors++; $display("FAIL mid_press_row got %h exp 7f", row_keys); end
      checks++; if (keyHit !== 1'b1) begin errors++; $display("FAIL mid_press_hit got %b exp 1", keyHit); end
      reset = 1'b1;
      tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL mid_rst_row got %h exp ff", row_keys); end
      checks++; if (keyHit !== 1'b0) begin errors++; $display("FAIL mid_rst_hit got %b exp 0", keyHit); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", inj_busy); end
      checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", inj_ready); end
      reset = 1'b0;
      tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL post_rst_row got %h exp ff", row_keys); end
      checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", inj_busy); end
   endtask

   task automatic test_overlap();
      col = 8'h00; row = 3'd0;
      wr_map({1'b0, 8'h55}, {1'b1, 3'd0, 3'd7});
      send(1'b0, 8'h55, 1'b1);
      tick();
      checks++; if (row_keys !== 8'h7F) begin errors++; $display("FAIL ovl_ps2 got %h exp 7f", row_keys); end
      ext_n[6] = 1'b0;
      tick();
      checks++; if (row_keys !== 8'h3F) begin errors++; $display("FAIL ovl_combine got %h exp 3f", row_keys); end
      ext_n[6] = 1'b1; ext_n[7] = 1'b0;
      clr_all = 1'b1; tick(); clr_all = 1'b0;
      tick();
      checks++; if (row_keys !== 8'h7F) begin errors++; $display("FAIL ovl_ext_holds got %h exp 7f", row_keys); end
      ext_n = '1;
      tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL ovl_release got %h exp ff", row_keys); end
      extd = 1'b0; code = 8'h55; make = 1'b1; strb = 1'b1;
      tick();
      strb = 1'b0; clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      tick();
      checks++; if (row_keys !== 8'hFF) begin errors++; $display("FAIL ovl_clr_prio got %h exp ff", row_keys); end
   endtask

   initial begin
      reset = 1'b1; strb = 1'b0; make = 1'b0; extd = 1'b0; code = 8'h00;
      map_we = 1'b0; map_addr = '0; map_data = '0; clr_all = 1'b0;
      inj_valid = 1'b0; inj_row = '0; inj_col = '0;
      ext_n = '1; row = '0; col = 8'hFF;
      test_reset();
      test_make_break();
      test_extended();
      test_invalid_and_rbw();
      test_injection();
      test_fifo_full();
      test_reset_mid_press();
      test_overlap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
